cvxif_accel_responder: RTL and testbench
========================================

# cvxif_accel_responder

Coprocessor-side responder for the CV-X-IF port the core drives when CvxifEn=1. It decodes custom-3 instructions offered on the issue interface, executes them, and tracks commit/kill from the core. Results return on the result interface under valid/ready. Single-entry, in-order: one instruction in flight; it sits beside the core's CV-X-IF initiator in the 32-bit configuration.

## Interface
Parameters
- XLEN, 32, operand/result width; must equal core XLEN.
- IdWidth, 3, transaction ID width; must match the core's CV-X-IF ID width.

Ports
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  reset, synchronous, active-low.
- issue_valid_i  in  1  core offers instruction.
- issue_ready_o  out  1  responder takes the offer this cycle.
- issue_instr_i  in  32  uncompressed instruction.
- issue_id_i  in  IdWidth  transaction ID.
- issue_rs_i  in  2*XLEN  {rs2, rs1} values.
- issue_rs_valid_i  in  2  per-operand valid.
- issue_accept_o  out  1  instruction is ours (comb, meaningful while issue_valid_i).
- issue_writeback_o  out  1  instruction writes rd.
- commit_valid_i  in  1  commit message valid.
- commit_id_i  in  IdWidth  committed/killed ID.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result presented.
- result_ready_i  in  1  core consumes result.
- result_id_o  out  IdWidth  ID of result.
- result_data_o  out  XLEN  result value.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  write rd.

## Operation
- Decode: accept iff opcode=7'b1111011, funct7=0, and funct3 is one of:
  - 000 ADD: rd=rs1+rs2, needs rs1, rs2, writeback=1.
  - 001 MUL: rd=low XLEN of rs1*rs2 (unsigned), needs rs1, rs2, writeback=1.
  - 010 NOP: no operands, writeback=0.
- Anything else: accept=0, writeback=0.
- issue_ready_o = (state==IDLE) && (!accept || required rs_valid bits all 1).
- Issue handshake = issue_valid_i && issue_ready_o.
  - Rejected instruction: handshake completes; state stays IDLE.
  - Accepted instruction: latch id, rd, op, operands; set committed=0; go to EXEC.
- FSM states: IDLE, EXEC, WAIT_COMMIT, RESULT.
  - EXEC → WAIT_COMMIT when the op completes: ADD/NOP 1 cycle, MUL XLEN cycles via shift-add.
  - WAIT_COMMIT → RESULT once committed=1; goes in the same cycle if commit arrives then.
  - RESULT → IDLE on result_valid_o && result_ready_i.
- Commit: commit_valid_i with commit_id_i == latched id in EXEC or WAIT_COMMIT.
  - kill=0 sets committed.
  - kill=1 aborts to IDLE next cycle with no result, including mid-MUL.
  - Non-matching IDs are ignored, as is a commit on the handshake cycle or in IDLE/RESULT.
- NOP still returns a result: result_we_o=0, data 0.
- Outputs result_* are registered and stable while result_valid_o=1 && !result_ready_i.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.

## Timing
- During reset and first cycle after: issue_ready_o=0, result_valid_o=0, result_data_o=0, result_id_o=0, result_rd_o=0, result_we_o=0, state IDLE, committed=0.
- Reset asserted mid-operation discards everything at the next edge.
- Latency, issue handshake to result_valid_o with commit already received:
  - ADD/NOP: 2 cycles.
  - MUL: XLEN+1 cycles.
- After a result handshake, issue_ready_o may rise the next cycle, not the same cycle.
- issue_accept_o and issue_writeback_o are purely combinational from issue_instr_i.

## Structure
- Package cvxif_accel_pkg holds:
  - custom-3 opcode constant.
  - funct3 enum (ADD/MUL/NOP).
  - FSM state enum.
  - decode function returning {accept, writeback, rs_needed[1:0]}.
- Sub-module cvxif_serial_mul: start/done handshake, XLEN-cycle shift-add multiplier with synchronous flush input driven by kill.

## Test plan
- ADD rs1=5, rs2=7, id=3, rd=x10, commit id 3 the next cycle → result_valid_o 2 cycles after issue, data=12, rd=10, we=1, id=3.
- MUL rs1=0xFFFF_FFFF, rs2=3, commit early → data=0xFFFF_FFFD exactly 33 cycles after issue.
- Kill mid-MUL (cycle 10) with matching id → no result_valid_o; issue_ready_o=1 next cycle; following ADD 1+1 returns 2.
- funct3=111 offered → issue_ready_o=1, accept=0, state stays IDLE, no result.
- ADD 2+2 with result_ready_i held 0 for 5 cycles → result_* stable, issue_ready_o=0 throughout; ready=1 → IDLE next cycle.
- Commit with wrong id during WAIT_COMMIT → no result; then correct id → RESULT next cycle; rst_ni=0 mid-MUL → all outputs 0 next edge.

Source files
------------

// File: rtl/cvxif_accel_pkg.sv
// Shared types and decode helper for the custom-3 CV-X-IF accelerator responder.
package cvxif_accel_pkg;

  localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;

  typedef enum logic [2:0] {
    F3_ADD = 3'b000,
    F3_MUL = 3'b001,
    F3_NOP = 3'b010
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_COMMIT,
    S_RESULT
  } state_e;

  // rs_needed[0] = rs1, rs_needed[1] = rs2
  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic [1:0] rs_needed;
  } decode_t;

  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d = '0;
    if (instr[6:0] == OPCODE_CUSTOM3 && instr[31:25] == 7'b0) begin
      case (instr[14:12])
        F3_ADD, F3_MUL: d = '{accept: 1'b1, writeback: 1'b1, rs_needed: 2'b11};
        F3_NOP:         d = '{accept: 1'b1, writeback: 1'b0, rs_needed: 2'b00};
        default:        d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cvxif_serial_mul.sv
// Shift-add multiplier: one partial product per cycle, XLEN cycles, low XLEN bits kept.
module cvxif_serial_mul #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            r_busy;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;

  // done flags the cycle whose closing edge performs the final step
  assign done_o    = r_busy && (r_cnt == CW'(XLEN - 1));
  assign product_o = r_acc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (flush_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start_i) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_a    <= a_i;
      r_b    <= b_i;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= r_acc + (r_b[0] ? r_a : '0);
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (done_o) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/cvxif_accel_responder.sv
// Single-entry CV-X-IF coprocessor: decodes custom-3 ADD/MUL/NOP, waits for commit, returns result.
module cvxif_accel_responder
  import cvxif_accel_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [IdWidth-1:0]  issue_id_i,
  input  logic [2*XLEN-1:0]   issue_rs_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [IdWidth-1:0]  commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [IdWidth-1:0]  result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o
);

  state_e              r_state, w_next;
  logic                r_live;
  logic                r_committed;
  logic                r_wb;
  funct3_e             r_op;
  logic [IdWidth-1:0]  r_id;
  logic [4:0]          r_rd;
  logic [XLEN-1:0]     r_rs1, r_rs2;
  logic [IdWidth-1:0]  r_res_id;
  logic [XLEN-1:0]     r_res_data;
  logic [4:0]          r_res_rd;
  logic                r_res_we;

  decode_t             w_dec;
  logic                w_rs_ok, w_take, w_commit_hit, w_kill, w_commit, w_exec_done;
  logic                w_mul_done;
  logic [XLEN-1:0]     w_mul_product, w_result;

  assign w_dec             = decode(issue_instr_i);
  assign issue_accept_o    = w_dec.accept;
  assign issue_writeback_o = w_dec.writeback;
  assign w_rs_ok           = &(issue_rs_valid_i | ~w_dec.rs_needed);
  // r_live holds ready low for the first cycle out of reset
  assign issue_ready_o     = rst_ni && r_live && (r_state == S_IDLE) && (!w_dec.accept || w_rs_ok);
  assign w_take            = issue_valid_i && issue_ready_o && w_dec.accept;

  assign w_commit_hit = commit_valid_i && (commit_id_i == r_id) &&
                        (r_state == S_EXEC || r_state == S_WAIT_COMMIT);
  assign w_kill       = w_commit_hit && commit_kill_i;
  assign w_commit     = w_commit_hit && !commit_kill_i;
  assign w_exec_done  = (r_op == F3_MUL) ? w_mul_done : 1'b1;

  cvxif_serial_mul #(.XLEN(XLEN)) u_mul (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (w_take && (issue_instr_i[14:12] == F3_MUL)),
    .flush_i   (w_kill),
    .a_i       (issue_rs_i[XLEN-1:0]),
    .b_i       (issue_rs_i[2*XLEN-1:XLEN]),
    .done_o    (w_mul_done),
    .product_o (w_mul_product)
  );

  always_comb begin
    w_result = '0;
    case (r_op)
      F3_ADD:  w_result = r_rs1 + r_rs2;
      F3_MUL:  w_result = w_mul_product;
      default: w_result = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:        if (w_take) w_next = S_EXEC;
      S_EXEC:        if (w_kill) w_next = S_IDLE;
                     else if (w_exec_done) w_next = S_WAIT_COMMIT;
      S_WAIT_COMMIT: if (w_kill) w_next = S_IDLE;
                     else if (r_committed || w_commit) w_next = S_RESULT;
      S_RESULT:      if (result_ready_i) w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_live      <= 1'b0;
      r_committed <= 1'b0;
      r_wb        <= 1'b0;
      r_op        <= F3_ADD;
      r_id        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
      r_res_we    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_take) begin
        r_committed <= 1'b0;
        r_wb        <= w_dec.writeback;
        r_op        <= funct3_e'(issue_instr_i[14:12]);
        r_id        <= issue_id_i;
        r_rd        <= issue_instr_i[11:7];
        r_rs1       <= issue_rs_i[XLEN-1:0];
        r_rs2       <= issue_rs_i[2*XLEN-1:XLEN];
      end else if (w_commit) begin
        r_committed <= 1'b1;
      end
      if (r_state == S_WAIT_COMMIT && w_next == S_RESULT) begin
        r_res_id   <= r_id;
        r_res_data <= w_result;
        r_res_rd   <= r_rd;
        r_res_we   <= r_wb;
      end
    end
  end

  assign result_valid_o = (r_state == S_RESULT);
  assign result_id_o    = r_res_id;
  assign result_data_o  = r_res_data;
  assign result_rd_o    = r_res_rd;
  assign result_we_o    = r_res_we;

endmodule

// File: tb/tb_cvxif_accel_responder.sv
// Self-checking bench for cvxif_accel_responder against a transaction-level reference model.
module tb_cvxif_accel_responder;

  localparam int unsigned XLEN = 32;
  localparam int unsigned IDW  = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [IDW-1:0]  issue_id_i;
  logic [63:0]     issue_rs_i;
  logic [1:0]      issue_rs_valid_i;
  logic            issue_accept_o;
  logic            issue_writeback_o;
  logic            commit_valid_i;
  logic [IDW-1:0]  commit_id_i;
  logic            commit_kill_i;
  logic            result_valid_o;
  logic            result_ready_i;
  logic [IDW-1:0]  result_id_o;
  logic [31:0]     result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  cvxif_accel_responder #(.XLEN(XLEN), .IdWidth(IDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs_i(issue_rs_i), .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  id;
    logic        stable;
    logic        rdy_low;
    logic        post_idle;
    logic        rdy_issue;
    logic        rdy_commit;
  } obs_t;

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0, 5'd2, 5'd1, f3, rd, 7'b1111011};
  endfunction

  // Reference model: result value of an op
  function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    if (f3 == 3'd0) return a + b;
    if (f3 == 3'd1) return p[31:0];
    return 32'd0;
  endfunction

  // Reference model: edge (after issue) at which a committed op presents its result
  function automatic int ref_lat(input logic [2:0] f3, input int commit_at);
    int exec_len;
    exec_len = (f3 == 3'd1) ? int'(XLEN) : 1;
    return (commit_at > exec_len + 1) ? commit_at : exec_len + 1;
  endfunction

  // Drives one full transaction and reports what the DUT did; the caller judges it.
  task automatic run_txn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] id, input logic [4:0] rd,
                         input int commit_at, input logic kill,
                         input int extra_at, input logic [2:0] extra_id,
                         input int stall, output obs_t o);
    o = '{lat: -1, data: '0, rd: '0, we: 1'b0, id: '0, stable: 1'b1, rdy_low: 1'b1,
          post_idle: 1'b0, rdy_issue: 1'b0, rdy_commit: 1'b0};
    issue_valid_i    = 1'b1;
    issue_instr_i    = mk_instr(f3, rd);
    issue_id_i       = id;
    issue_rs_i       = {b, a};
    issue_rs_valid_i = 2'b11;
    commit_valid_i   = (extra_at == 0);
    commit_id_i      = extra_id;
    commit_kill_i    = 1'b0;
    #1 o.rdy_issue = issue_ready_o;
    @(posedge clk_i); #1;
    issue_valid_i  = 1'b0;
    issue_instr_i  = '0;
    for (int k = 1; k <= 50; k++) begin
      commit_valid_i = (k == commit_at) || (k == extra_at);
      commit_id_i    = (k == commit_at) ? id : extra_id;
      commit_kill_i  = (k == commit_at) && kill;
      @(posedge clk_i); #1;
      commit_valid_i = 1'b0;
      if (k == commit_at) o.rdy_commit = issue_ready_o;
      if (result_valid_o) begin
        o.lat = k;
        break;
      end
    end
    if (o.lat >= 0) begin
      o.data = result_data_o; o.rd = result_rd_o; o.we = result_we_o; o.id = result_id_o;
      if (issue_ready_o) o.rdy_low = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk_i); #1;
        if (!result_valid_o || result_data_o !== o.data || result_rd_o !== o.rd ||
            result_we_o !== o.we || result_id_o !== o.id) o.stable = 1'b0;
        if (issue_ready_o) o.rdy_low = 1'b0;
      end
      result_ready_i = 1'b1;
      @(posedge clk_i); #1;
      result_ready_i = 1'b0;
    end
    o.post_idle = issue_ready_o && !result_valid_o;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if ({issue_ready_o, result_valid_o, result_we_o} !== 3'b000) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 000", {issue_ready_o, result_valid_o, result_we_o}); end
    n_checks++; if ({result_data_o, result_id_o, result_rd_o} !== '0) begin
      n_errors++; $display("FAIL reset_data: got %h/%h/%h expected 0", result_data_o, result_id_o, result_rd_o); end
    rst_ni = 1'b1;
    #1;
    n_checks++; if (issue_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_first_cycle_ready: got %b expected 0", issue_ready_o); end
    @(posedge clk_i); #1;
    n_checks++; if (issue_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready_rise: got %b expected 1", issue_ready_o); end
  endtask

  task automatic test_decode();
    logic [31:0] ins;
    logic        exp_acc, exp_wb;
    issue_valid_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ins = $urandom;
      if ($urandom_range(1, 0) == 1) ins[6:0] = 7'b1111011;
      if ($urandom_range(1, 0) == 1) ins[31:25] = '0;
      exp_acc = (ins[6:0] == 7'b1111011) && (ins[31:25] == 7'd0) && (ins[14:12] <= 3'd2);
      exp_wb  = exp_acc && (ins[14:12] != 3'd2);
      issue_instr_i = ins;
      #1;
      n_checks++; if ({issue_accept_o, issue_writeback_o} !== {exp_acc, exp_wb}) begin
        n_errors++; $display("FAIL decode %h: got %b expected %b", ins, {issue_accept_o, issue_writeback_o}, {exp_acc, exp_wb}); end
    end
    issue_instr_i = mk_instr(3'd0, 5'd1); issue_rs_valid_i = 2'b01; #1;
    n_checks++; if (issue_ready_o !== 1'b0) begin
      n_errors++; $display("FAIL add_missing_rs2_ready: got %b expected 0", issue_ready_o); end
    issue_instr_i = mk_instr(3'd2, 5'd1); issue_rs_valid_i = 2'b00; #1;
    n_checks++; if (issue_ready_o !== 1'b1) begin
      n_errors++; $display("FAIL nop_no_rs_ready: got %b expected 1", issue_ready_o); end
    issue_instr_i = '0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_add();
    obs_t o;
    run_txn(3'd0, 32'd5, 32'd7, 3'd3, 5'd10, 1, 1'b0, -1, 3'd0, 0, o);
    n_checks++; if (o.lat !== 2) begin n_errors++; $display("FAIL add_latency: got %0d expected 2", o.lat); end
    n_checks++; if (o.data !== 32'd12) begin n_errors++; $display("FAIL add_data: got %0d expected 12", o.data); end
    n_checks++; if ({o.rd, o.we, o.id} !== {5'd10, 1'b1, 3'd3}) begin
      n_errors++; $display("FAIL add_rd_we_id: got %0d/%b/%0d expected 10/1/3", o.rd, o.we, o.id); end
    n_checks++; if (!o.post_idle) begin n_errors++; $display("FAIL add_idle_after: got 0 expected 1"); end
  endtask

  task automatic test_mul();
    obs_t o;
    run_txn(3'd1, 32'hFFFF_FFFF, 32'd3, 3'd1, 5'd4, 1, 1'b0, -1, 3'd0, 0, o);
    n_checks++; if (o.lat !== 33) begin n_errors++; $display("FAIL mul_latency: got %0d expected 33", o.lat); end
    n_checks++; if (o.data !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL mul_data: got %h expected fffffffd", o.data); end
  endtask

  task automatic test_kill_mul();
    obs_t o;
    run_txn(3'd1, $urandom, $urandom, 3'd6, 5'd9, 10, 1'b1, -1, 3'd0, 0, o);
    n_checks++; if (o.lat !== -1) begin n_errors++; $display("FAIL kill_no_result: got lat %0d expected none", o.lat); end
    n_checks++; if (!o.rdy_commit) begin n_errors++; $display("FAIL kill_ready_next: got 0 expected 1"); end
    run_txn(3'd0, 32'd1, 32'd1, 3'd2, 5'd3, 1, 1'b0, -1, 3'd0, 0, o);
    n_checks++; if (o.data !== 32'd2 || o.lat !== 2) begin
      n_errors++; $display("FAIL add_after_kill: got %0d@%0d expected 2@2", o.data, o.lat); end
  endtask

  task automatic test_reject();
    issue_valid_i = 1'b1; issue_instr_i = mk_instr(3'd7, 5'd5); issue_rs_valid_i = 2'b00;
    #1;
    n_checks++; if ({issue_ready_o, issue_accept_o} !== 2'b10) begin
      n_errors++; $display("FAIL reject_ready_accept: got %b expected 10", {issue_ready_o, issue_accept_o}); end
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; issue_instr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++; if ({issue_ready_o, result_valid_o} !== 2'b10) begin
      n_errors++; $display("FAIL reject_stays_idle: got %b expected 10", {issue_ready_o, result_valid_o}); end
  endtask

  task automatic test_stall();
    obs_t o;
    run_txn(3'd0, 32'd2, 32'd2, 3'd4, 5'd7, 1, 1'b0, -1, 3'd0, 5, o);
    n_checks++; if (o.data !== 32'd4) begin n_errors++; $display("FAIL stall_data: got %0d expected 4", o.data); end
    n_checks++; if (!o.stable) begin n_errors++; $display("FAIL stall_stable: got 0 expected 1"); end
    n_checks++; if (!o.rdy_low) begin n_errors++; $display("FAIL stall_ready_low: got 0 expected 1"); end
    n_checks++; if (!o.post_idle) begin n_errors++; $display("FAIL stall_idle_after: got 0 expected 1"); end
  endtask

  task automatic test_commit_filter();
    obs_t o;
    run_txn(3'd0, 32'd9, 32'd1, 3'd5, 5'd1, 6, 1'b0, 3, 3'd2, 0, o);
    n_checks++; if (o.lat !== 6) begin n_errors++; $display("FAIL wrong_id_ignored: got %0d expected 6", o.lat); end
    run_txn(3'd0, 32'd9, 32'd1, 3'd5, 5'd1, 5, 1'b0, 0, 3'd5, 0, o);
    n_checks++; if (o.lat !== 5) begin n_errors++; $display("FAIL handshake_commit_ignored: got %0d expected 5", o.lat); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic [2:0]  f3, id;
    logic [4:0]  rd;
    logic [31:0] a, b;
    logic        kill;
    int          c, exp_lat;
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(2, 0)); id = 3'($urandom); rd = 5'($urandom);
      a = $urandom; b = $urandom; c = $urandom_range(40, 1);
      kill = ($urandom_range(4, 0) == 0);
      run_txn(f3, a, b, id, rd, c, kill, -1, 3'd0, $urandom_range(3, 0), o);
      exp_lat = kill ? -1 : ref_lat(f3, c);
      n_checks++; if (o.lat !== exp_lat) begin
        n_errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, o.lat, exp_lat); end
      if (!kill) begin
        n_checks++; if ({o.data, o.rd, o.we, o.id} !== {ref_data(f3, a, b), rd, f3 != 3'd2, id}) begin
          n_errors++; $display("FAIL rand%0d_result: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d", i,
            o.data, o.rd, o.we, o.id, ref_data(f3, a, b), rd, f3 != 3'd2, id); end
        n_checks++; if (!o.stable) begin n_errors++; $display("FAIL rand%0d_stable: got 0 expected 1", i); end
      end
      n_checks++; if (!o.post_idle) begin n_errors++; $display("FAIL rand%0d_idle: got 0 expected 1", i); end
    end
  endtask

  task automatic test_reset_mid_mul();
    issue_valid_i = 1'b1; issue_instr_i = mk_instr(3'd1, 5'd8); issue_id_i = 3'd7;
    issue_rs_i = {32'd3, 32'd11}; issue_rs_valid_i = 2'b11;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0; issue_instr_i = '0;
    repeat (10) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    n_checks++; if ({issue_ready_o, result_valid_o, result_we_o, result_data_o, result_id_o, result_rd_o} !== '0) begin
      n_errors++; $display("FAIL reset_mid_mul: got %b/%b/%b/%h/%0d/%0d expected all 0", issue_ready_o,
        result_valid_o, result_we_o, result_data_o, result_id_o, result_rd_o); end
    rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (issue_ready_o !== 1'b1 || result_valid_o !== 1'b0) begin
      n_errors++; $display("FAIL after_reset_idle: got %b%b expected 10", issue_ready_o, result_valid_o); end
  endtask

  initial begin
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_id_i = '0; issue_rs_i = '0;
    issue_rs_valid_i = 2'b00; commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    result_ready_i = 1'b0;
    test_reset();
    test_decode();
    test_add();
    test_mul();
    test_kill_mul();
    test_reject();
    test_stall();
    test_commit_filter();
    test_random();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
